stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, storage entries; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit, synchronous clear of contents.
REQ-006 The block SHALL have port s_valid, input, 1 bit, upstream word present.
REQ-007 The block SHALL have port s_ready, output, 1 bit, FIFO accepts word.
REQ-008 The block SHALL have port s_data, input, DATA_WIDTH bits, upstream payload.
REQ-009 The block SHALL have port m_valid, output, 1 bit, head word present.
REQ-010 The block SHALL have port m_ready, input, 1 bit, downstream accepts word.
REQ-011 The block SHALL have port m_data, output, DATA_WIDTH bits, head payload.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, current occupancy.
REQ-013 The block SHALL have ports full and empty, output, 1 bit each, occupancy flags.

Function
REQ-014 A push SHALL occur on a rising edge where s_valid=1 and s_ready=1; a pop SHALL occur where m_valid=1 and m_ready=1.
REQ-015 s_ready SHALL equal !full, registered-state-derived only, with no combinational path from m_ready.
REQ-016 m_valid SHALL equal !empty; m_data SHALL present the oldest stored word whenever m_valid=1 (first-word fall-through).
REQ-017 Latency SHALL be one cycle: a word pushed at edge N appears on m_valid/m_data after edge N when the FIFO was empty.
REQ-018 Write and read pointers SHALL be $clog2(DEPTH)-bit counters that wrap from DEPTH-1 to 0 with no gap.
REQ-019 count SHALL update as follows: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop, or on neither.
REQ-020 full SHALL be 1 iff count==DEPTH; empty SHALL be 1 iff count==0.
REQ-021 When full, a push SHALL NOT occur even if a pop occurs in the same cycle; s_ready returns to 1 the cycle after the pop.
REQ-022 When empty, no pop SHALL occur and m_data is don't-care; simultaneous s_valid with empty SHALL push only.
REQ-023 Simultaneous push and pop at any non-full, non-empty occupancy SHALL store the new word and retire the head in the same edge.
REQ-024 s_data and m_valid/m_data SHALL obey valid/ready rules: once m_valid=1, m_data SHALL hold stable until popped, flush or reset.
REQ-025 Data SHALL exit in exact push order with no loss, duplication or corruption.
REQ-026 When flush=1, the next edge SHALL set pointers and count to 0, ignoring any simultaneous push or pop; flush has priority over both.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL clear both pointers and count to 0; rst has priority over flush, push and pop.
REQ-028 After reset, outputs SHALL be: s_ready=1, m_valid=0, count=0, full=0, empty=1; m_data is don't-care.
REQ-029 Storage array contents SHALL NOT require reset.
REQ-030 Reset asserted mid-burst SHALL discard all stored words; no pre-reset word SHALL appear on m_data afterwards.

Verification (DATA_WIDTH=8, DEPTH=16)
REQ-031 Bench SHALL fill with m_ready=0 and pushes 0x00..0x0F: count=16, full=1, s_ready=0; then drain with m_ready=1: 0x00..0x0F in order, empty=1.
REQ-032 Bench SHALL hold continuous push/pop at count=5 for 40 cycles: count stays 5, order preserved, pointers wrap at least twice.
REQ-033 Bench SHALL test full with s_valid=1, m_ready=1: one pop, no push that cycle, count=15; next cycle push accepted, count=16.
REQ-034 Bench SHALL push 0xA5 into an empty FIFO at edge N: m_valid=1, m_data=0xA5 after edge N; count=1.
REQ-035 Bench SHALL assert flush with s_valid=1, m_ready=1 at count=7: next cycle count=0, empty=1, s_ready=1, pushed word lost.
REQ-036 Bench SHALL assert rst with flush=1 and s_valid=1 at count=9: all reset values per REQ-028; the subsequent push of 0x3C is the first word out.

Source files
------------

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on both sides, occupancy count, full/empty flags and flush.
//
// Ports:
//   clk     - rising-edge clock for all state
//   rst     - synchronous active-high reset; clears pointers and count
//   flush   - synchronous clear of contents; lower priority than rst
//   s_valid - upstream word present
//   s_ready - FIFO can accept a word (equals !full)
//   s_data  - upstream payload
//   m_valid - head word present (equals !empty)
//   m_ready - downstream accepts the head word
//   m_data  - head payload, valid whenever m_valid=1
//   count   - current occupancy, 0..DEPTH
//   full    - count == DEPTH
//   empty   - count == 0

module stream_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;

   logic push;
   logic pop;
   logic wr_en;

   // Flags come straight from the count register, so s_ready has no
   // combinational dependence on m_ready: a full FIFO refuses a push
   // even when the head is being popped in the same cycle.
   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign s_ready = ~full;
   assign m_valid = ~empty;
   assign count   = cnt_q;

   assign push = s_valid & ~full;
   assign pop  = m_ready & ~empty;

   // Head word is read directly from storage (fall-through).
   assign m_data = mem[rd_ptr];

   // Storage is not reset; pointers alone define what is valid.
   assign wr_en = push & ~flush & ~rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= s_data;
      end
   end

   // Pointers are AW-bit counters; DEPTH is a power of two so the
   // natural rollover wraps DEPTH-1 -> 0 with no gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: randomized and directed checks of stream_fifo against
// a queue-based reference model of FIFO behaviour.

module tb_stream_fifo;

   localparam int DW = 8;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [4:0]    count;
   logic          full;
   logic          empty;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] q[$];

   always #5 clk = ~clk;

   stream_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data),
      .count(count),
      .full(full),
      .empty(empty)
   );

   // One clock edge; the model applies FIFO rules using pre-edge occupancy.
   task automatic tick();
      int  n;
      bit  pu;
      bit  po;
      n = q.size();
      @(posedge clk);
      if (rst || flush) begin
         q.delete();
      end else begin
         po = (n > 0) && m_ready;
         pu = s_valid && (n < D);
         if (po) void'(q.pop_front());
         if (pu) q.push_back(s_data);
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
      s_valid = v;
      s_data  = d;
      m_ready = r;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total += 5;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
      if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 0; i < D; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      total += 3;
      if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
      if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
      if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
      for (int i = 0; i < D; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         total++;
         if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
            bad++;
            $display("FAIL drain_word%0d got=%h/%b exp=%h/1", i, m_data, m_valid, 8'(i));
         end
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      total += 2;
      if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
      if (count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
   endtask

   task automatic test_latency();
      do_reset();
      drive(1'b1, 8'hA5, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      total += 3;
      if (m_valid !== 1'b1) begin bad++; $display("FAIL lat_m_valid got=%b exp=1", m_valid); end
      if (m_data !== 8'hA5) begin bad++; $display("FAIL lat_m_data got=%h exp=a5", m_data); end
      if (count !== 5'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'($urandom), 1'b1);
         tick();
         total += 2;
         if (count !== 5'(q.size()) || count !== 5'd5) begin
            bad++;
            $display("FAIL b2b_count cyc=%0d got=%0d exp=5", i, count);
         end
         if (m_data !== q[0]) begin
            bad++;
            $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, m_data, q[0]);
         end
      end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_full_pop();
      logic [DW-1:0] exp_head;
      do_reset();
      for (int i = 0; i < D; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      exp_head = q[1];
      drive(1'b1, 8'h77, 1'b1);
      tick();
      total += 3;
      if (count !== 5'd15) begin bad++; $display("FAIL fullpop_count got=%0d exp=15", count); end
      if (s_ready !== 1'b1) begin bad++; $display("FAIL fullpop_s_ready got=%b exp=1", s_ready); end
      if (m_data !== exp_head) begin bad++; $display("FAIL fullpop_head got=%h exp=%h", m_data, exp_head); end
      drive(1'b1, 8'h77, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      total += 2;
      if (count !== 5'd16) begin bad++; $display("FAIL fullpush_count got=%0d exp=16", count); end
      if (full !== 1'b1) begin bad++; $display("FAIL fullpush_full got=%b exp=1", full); end
      for (int i = 0; i < D; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         total++;
         if (m_data !== q[0]) begin
            bad++;
            $display("FAIL fullpop_drain%0d got=%h exp=%h", i, m_data, q[0]);
         end
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      flush = 1'b1;
      drive(1'b1, 8'hEE, 1'b1);
      tick();
      flush = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      total += 4;
      if (count !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
      if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
      if (s_ready !== 1'b1) begin bad++; $display("FAIL flush_s_ready got=%b exp=1", s_ready); end
      if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_m_valid got=%b exp=0", m_valid); end
      drive(1'b1, 8'h11, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      total++;
      if (m_data !== 8'h11 || count !== 5'd1) begin
         bad++;
         $display("FAIL flush_next got=%h/%0d exp=11/1", m_data, count);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      rst   = 1'b1;
      flush = 1'b1;
      drive(1'b1, 8'hD2, 1'b0);
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      total += 5;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_s_ready got=%b exp=1", s_ready); end
      if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_m_valid got=%b exp=0", m_valid); end
      if (count !== 5'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", count); end
      if (full !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b exp=0", full); end
      if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
      drive(1'b1, 8'h3C, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      total++;
      if (m_data !== 8'h3C || count !== 5'd1) begin
         bad++;
         $display("FAIL rstmid_first got=%h/%0d exp=3c/1", m_data, count);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         flush = ($urandom_range(0, 40) == 0);
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
               1'($urandom_range(0, 2) != 0));
         tick();
         total += 4;
         if (count !== 5'(q.size())) begin
            bad++;
            $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, q.size());
         end
         if (m_valid !== (q.size() != 0)) begin
            bad++;
            $display("FAIL rnd_m_valid cyc=%0d got=%b", i, m_valid);
         end
         if (s_ready !== (q.size() != D)) begin
            bad++;
            $display("FAIL rnd_s_ready cyc=%0d got=%b", i, s_ready);
         end
         if (q.size() != 0 && m_data !== q[0]) begin
            bad++;
            $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, m_data, q[0]);
         end
      end
      flush = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      rst   = 1'b0;
      flush = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      #2;
      test_reset();
      test_fill_drain();
      test_latency();
      test_back_to_back();
      test_full_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
